// File: rtl/gate_pipe.sv
// gate_pipe: a row of CH bitwise gates on shared operands, behind a two-entry
// valid/ready pipeline made of an output register and one skid register.
//
// Every channel computes the same two operands with its own 2-bit opcode:
//   00 NOR, 01 NAND, 10 OR, 11 XOR
// The results of one beat are captured at the accepting edge. They show up
// on OUT one cycle later, or later still while the consumer is stalling.
//
// Ports
//   CLK        sole clock, rising edge
//   RST_N      synchronous active-low reset
//   IN_A/IN_B  WIDTH-bit operands shared by all channels
//   OP         2*CH opcode bits, channel k uses OP[2k+1:2k]
//   IN_VALID   upstream presents a beat
//   IN_READY   registered; high exactly when the skid register is empty
//   OUT        CH*WIDTH results, channel k at OUT[(k+1)*WIDTH-1:k*WIDTH]
//   OUT_VALID  OUT holds a beat
//   OUT_READY  downstream takes OUT this cycle
//   TXN_CNT    16-bit count of completed output transfers, wraps at 0xFFFF.
//              This port exists only when GATE_PIPE_CNT_EN is defined.
//
// Build option: define GATE_PIPE_CNT_EN to add the transfer counter.

module gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CH    = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [WIDTH-1:0]      IN_A,
    input  logic [WIDTH-1:0]      IN_B,
    input  logic [2*CH-1:0]       OP,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [CH*WIDTH-1:0]   OUT,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY
`ifdef GATE_PIPE_CNT_EN
    ,
    output logic [15:0]           TXN_CNT
`endif
);

    // Per-channel gate results for the beat currently on the inputs.
    logic [CH*WIDTH-1:0] gate_res;

    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
        logic [1:0] op_k;
        assign op_k = OP[2*gi +: 2];
        assign gate_res[gi*WIDTH +: WIDTH] =
            (op_k == 2'b00) ? ~(IN_A | IN_B) :
            (op_k == 2'b01) ? ~(IN_A & IN_B) :
            (op_k == 2'b10) ?  (IN_A | IN_B) :
                               (IN_A ^ IN_B);
    end

    logic [CH*WIDTH-1:0] out_data_reg,  out_data_next;
    logic                out_valid_reg, out_valid_next;
    logic [CH*WIDTH-1:0] skid_data_reg, skid_data_next;
    logic                skid_valid_reg, skid_valid_next;
    logic                in_ready_reg;

    logic accept;
    logic out_load;

    assign accept   = IN_VALID && in_ready_reg;
    // The output stage can take new contents when it is empty or draining.
    assign out_load = !out_valid_reg || OUT_READY;

    always_comb begin
        out_data_next   = out_data_reg;
        out_valid_next  = out_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_valid_next = skid_valid_reg;
        if (out_load) begin
            if (skid_valid_reg) begin
                // The older beat waiting in skid goes first. IN_READY is low
                // in this state, so no new beat competes for the slot.
                out_data_next   = skid_data_reg;
                out_valid_next  = 1'b1;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                out_data_next  = gate_res;
                out_valid_next = 1'b1;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (accept) begin
            // The output is stalled and full, so the beat parks in skid.
            skid_data_next  = gate_res;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            skid_data_reg  <= '0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
        end else begin
            out_data_reg   <= out_data_next;
            out_valid_reg  <= out_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_valid_reg <= skid_valid_next;
            // Register the ready flag from the next skid state. This keeps
            // IN_READY free of any combinational path from OUT_READY.
            in_ready_reg   <= !skid_valid_next;
        end
    end

    assign OUT       = out_data_reg;
    assign OUT_VALID = out_valid_reg;
    assign IN_READY  = in_ready_reg;

`ifdef GATE_PIPE_CNT_EN
    logic [15:0] txn_cnt_reg;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            txn_cnt_reg <= '0;
        end else if (out_valid_reg && OUT_READY) begin
            txn_cnt_reg <= txn_cnt_reg + 16'd1;
        end
    end

    assign TXN_CNT = txn_cnt_reg;
`endif

endmodule

// File: doc/gate_pipe.md
GATE_PIPE -- requirements
Module: gate_pipe

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each operand and each channel result.
REQ-002 Parameter CH, default 3, number of independent gate channels.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  synchronous active-low reset, sampled on rising CLK.
REQ-005 IN_A  input  WIDTH  operand A, shared by all channels.
REQ-006 IN_B  input  WIDTH  operand B, shared by all channels.
REQ-007 OP  input  2*CH  per-channel opcode; channel k uses OP[2k+1:2k].
REQ-008 IN_VALID  input  1  upstream presents IN_A/IN_B/OP.
REQ-009 IN_READY  output  1  block can accept a beat this cycle.
REQ-010 OUT  output  CH*WIDTH  results; channel k occupies OUT[(k+1)*WIDTH-1:k*WIDTH].
REQ-011 OUT_VALID  output  1  OUT holds a valid beat.
REQ-012 OUT_READY  input  1  downstream accepts OUT this cycle.

Function
REQ-013 Opcodes SHALL be: 00 NOR, 01 NAND, 10 OR, 11 XOR, all bitwise on IN_A and IN_B.
REQ-014 A beat SHALL be accepted on a rising edge where IN_VALID=1 and IN_READY=1; the results are computed from the operands and OP sampled at that edge.
REQ-015 Storage SHALL be an output register plus one skid register; the block holds at most 2 beats.
REQ-016 IN_READY SHALL be driven from a register and equal 1 exactly when the skid register is empty.
REQ-017 The output register SHALL load when it is empty or OUT_READY=1: from skid if skid full, else from the accepted input beat, else it becomes empty.
REQ-018 An accepted beat SHALL go to the skid register only when the output register is full and OUT_READY=0.
REQ-019 Latency SHALL be 1 cycle: a beat accepted at edge t into an empty or draining output stage SHALL appear with OUT_VALID=1 after edge t.
REQ-020 Throughput SHALL be 1 beat per cycle while OUT_READY=1 continuously.
REQ-021 Beats SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-022 OUT and OUT_VALID SHALL remain stable while OUT_VALID=1 and OUT_READY=0.
REQ-023 When both stages are full and OUT_READY=1, skid SHALL move to output, skid SHALL become empty, and no input SHALL be accepted that edge.
REQ-024 A change of OP SHALL affect only beats accepted after the change.

Reset
REQ-025 With RST_N=0 at a rising edge: OUT_VALID=0, OUT=0, skid empty, skid data=0, IN_READY=1 after that edge.
REQ-026 Reset mid-transfer SHALL discard both held beats without presenting them.
REQ-027 Beats presented while RST_N=0 SHALL NOT be accepted.

Configuration
REQ-028 Macro GATE_PIPE_CNT_EN SHALL control a transaction counter.
REQ-029 With GATE_PIPE_CNT_EN defined: output TXN_CNT (16 bits) SHALL be present and SHALL increment by 1 on each edge with OUT_VALID=1 and OUT_READY=1; it SHALL reset to 0 and wrap 0xFFFF to 0x0000.
REQ-030 Without GATE_PIPE_CNT_EN: TXN_CNT SHALL be absent and no counter logic SHALL be built; all other behaviour SHALL be identical.

Verification
REQ-031 WIDTH=8, CH=3, OP=6'b10_01_00, A=0x0F, B=0x3C, OUT_READY=1 -> next cycle OUT={0x3F,0xF3,0xC0}, OUT_VALID=1.
REQ-032 OP channel 0 = 11, A=0xAA, B=0xFF -> channel 0 result 0x55.
REQ-033 OUT_READY=0, push beats X then Y -> OUT=X held, IN_READY=0 after Y; raise OUT_READY for 2 cycles -> X then Y emitted in order, IN_READY back to 1.
REQ-034 Continuous IN_VALID=1 and OUT_READY=1 for 20 cycles -> 20 beats out, no bubbles after the first.
REQ-035 RST_N=0 for one edge with both stages full -> OUT_VALID=0, OUT=0, IN_READY=1; neither held beat appears afterwards.
REQ-036 GATE_PIPE_CNT_EN defined, counter preset via 65535 transfers, one more transfer -> TXN_CNT=0x0000.
